// File: rtl/sc_game_defines_pkg.sv
// Shared encodings for the LED-matrix game:
// register commands, controller states, directions.
package sc_game_defines_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_MOVE = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_e;

  function automatic logic [1:0] dirToSel(dir_e d);
    logic [1:0] s;
    s = SEL_HOLD;
    if (d == DIR_LEFT)  s = SEL_LEFT;
    if (d == DIR_RIGHT) s = SEL_RIGHT;
    return s;
  endfunction

endpackage

// File: rtl/sc_repeat_timer.sv
// Auto-repeat counter; terminal flags the last cycle
// of a period and the count clears itself there.
module sc_repeat_timer #(
  parameter int WIDTH = 24,
  parameter int TICKS = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TICKS - 1);

  logic [WIDTH-1:0] count;

  assign terminal = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_player1_move_controller.sv
// Player-1 move sequencer: wall blocking, auto-repeat
// and start-pattern reload for the shift register.
module sc_player1_move_controller
  import sc_game_defines_pkg::*;
#(
  parameter int REPEAT_WIDTH = 24,
  parameter int REPEAT_TICKS = 12500000
) (
  input  logic       SC_PLAYER1MOVECTRL_CLOCK_50,
  input  logic       SC_PLAYER1MOVECTRL_RESET_InHigh,
  input  logic       SC_PLAYER1MOVECTRL_restart_In,
  input  logic       SC_PLAYER1MOVECTRL_left_InLow,
  input  logic       SC_PLAYER1MOVECTRL_right_InLow,
  input  logic       SC_PLAYER1MOVECTRL_leftfree_In,
  input  logic       SC_PLAYER1MOVECTRL_rightfree_In,
  output logic [1:0] SC_PLAYER1MOVECTRL_shiftsel_Out,
  output logic       SC_PLAYER1MOVECTRL_blocked_Out
);

  logic clk;
  logic rst;
  logic pressL;
  logic pressR;
  logic freeL;
  logic freeR;

  assign clk    = SC_PLAYER1MOVECTRL_CLOCK_50;
  assign rst    = SC_PLAYER1MOVECTRL_RESET_InHigh;
  assign pressL = ~SC_PLAYER1MOVECTRL_left_InLow;
  assign pressR = ~SC_PLAYER1MOVECTRL_right_InLow;
  assign freeL  = SC_PLAYER1MOVECTRL_leftfree_In;
  assign freeR  = SC_PLAYER1MOVECTRL_rightfree_In;

  state_e     state, stateNext;
  dir_e       dir, dirNext;
  logic [1:0] sel, selNext;
  logic       blocked, blockedNext;
  logic       tmrClr, tmrEn, terminal;
  logic       dirHeld, dirFree;

  sc_repeat_timer #(
    .WIDTH (REPEAT_WIDTH),
    .TICKS (REPEAT_TICKS)
  ) uTimer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmrClr),
    .en       (tmrEn),
    .terminal (terminal)
  );

  assign dirHeld = (dir == DIR_LEFT) ? pressL : pressR;
  assign dirFree = (dir == DIR_LEFT) ? freeL : freeR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      dir     <= DIR_NONE;
      sel     <= SEL_HOLD;
      blocked <= 1'b0;
    end else begin
      state   <= stateNext;
      dir     <= dirNext;
      sel     <= selNext;
      blocked <= blockedNext;
    end
  end

  always_comb begin
    stateNext   = state;
    dirNext     = dir;
    selNext     = SEL_HOLD;
    blockedNext = blocked;
    tmrClr      = 1'b0;
    tmrEn       = 1'b0;
    if (SC_PLAYER1MOVECTRL_restart_In) begin
      stateNext   = ST_INIT;
      dirNext     = DIR_NONE;
      blockedNext = 1'b0;
      tmrClr      = 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          stateNext   = ST_IDLE;
          selNext     = SEL_LOAD;
          dirNext     = DIR_NONE;
          blockedNext = 1'b0;
          tmrClr      = 1'b1;
        end
        ST_IDLE: begin
          tmrClr = 1'b1;
          // exactly one button: both or none means no move
          if (pressL ^ pressR) begin
            dirNext = pressL ? DIR_LEFT : DIR_RIGHT;
            if (pressL ? freeL : freeR) begin
              stateNext   = ST_MOVE;
              selNext     = pressL ? SEL_LEFT : SEL_RIGHT;
              blockedNext = 1'b0;
            end else begin
              stateNext   = ST_HOLD;
              blockedNext = 1'b1;
            end
          end
        end
        ST_MOVE: begin
          stateNext = ST_HOLD;
          tmrClr    = 1'b1;
        end
        ST_HOLD: begin
          if (!dirHeld) begin
            stateNext   = ST_IDLE;
            dirNext     = DIR_NONE;
            blockedNext = 1'b0;
            tmrClr      = 1'b1;
          end else begin
            tmrEn = 1'b1;
            if (terminal) begin
              if (dirFree) begin
                stateNext   = ST_MOVE;
                selNext     = dirToSel(dir);
                blockedNext = 1'b0;
              end else begin
                blockedNext = 1'b1;
              end
            end
          end
        end
        default: begin
          stateNext   = ST_INIT;
          dirNext     = DIR_NONE;
          blockedNext = 1'b0;
          tmrClr      = 1'b1;
        end
      endcase
    end
  end

  assign SC_PLAYER1MOVECTRL_shiftsel_Out = sel;
  assign SC_PLAYER1MOVECTRL_blocked_Out  = blocked;

endmodule
